// File: rtl/serial_slice_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_slice_comparator
//  Purpose  : MSB-first magnitude comparator, one 2-bit slice per clock
//             through a single shared slice stage.
//  Revision : 1.0  initial release
// ============================================================================
module serial_slice_comparator #(
    parameter int S          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [S-1:0]               a,
    input  logic [S-1:0]               b,
    output logic                       ready,
    output logic                       done,
    output logic                       EQ,
    output logic                       GT,
    output logic [$clog2(S/2+1)-1:0]   cycles
);

    localparam int c_n  = S / 2;
    localparam int c_cw = $clog2(c_n + 1);
    localparam int c_iw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_iw-1:0] c_idx_top = c_iw'(c_n - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [S-1:0]      r_a;
    logic [S-1:0]      r_b;
    logic              r_e;
    logic              r_g;
    logic [c_iw-1:0]   r_idx;
    logic [c_cw-1:0]   r_cnt;
    logic              r_eq;
    logic              r_gt;
    logic [c_cw-1:0]   r_cycles;

    logic [1:0]        w_a_s;
    logic [1:0]        w_b_s;
    logic              w_slice_eq;
    logic              w_slice_gt;
    logic              w_e_nxt;
    logic              w_g_nxt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic              w_leave;

    assign w_a_s      = r_a[{r_idx, 1'b0} +: 2];
    assign w_b_s      = r_b[{r_idx, 1'b0} +: 2];
    assign w_slice_eq = (w_a_s == w_b_s);
    assign w_slice_gt = (w_a_s > w_b_s);

    // Once e has dropped, the first difference is locked in and later slices are ignored.
    assign w_e_nxt    = r_e & w_slice_eq;
    assign w_g_nxt    = r_e ? w_slice_gt : r_g;
    assign w_cnt_nxt  = r_cnt + c_cw'(1);
    assign w_leave    = (r_idx == '0) || (EARLY_EXIT && !w_slice_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_leave) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_e      <= 1'b1;
            r_g      <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_eq     <= 1'b1;
            r_gt     <= 1'b0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_e   <= 1'b1;
                        r_g   <= 1'b0;
                        r_idx <= c_idx_top;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_e   <= w_e_nxt;
                    r_g   <= w_g_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (r_idx != '0) r_idx <= r_idx - c_iw'(1);
                    if (w_leave) begin
                        r_eq     <= w_e_nxt;
                        r_gt     <= w_g_nxt;
                        r_cycles <= w_cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign EQ     = r_eq;
    assign GT     = r_gt;
    assign cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_serial_slice_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_slice_comparator
//  Purpose  : Directed and random checks of both EARLY_EXIT variants in lockstep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_slice_comparator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic       ready_e, done_e, eq_e, gt_e;
    logic [2:0] cy_e;
    logic       ready_f, done_f, eq_f, gt_f;
    logic [2:0] cy_f;

    int checks = 0;
    int errors = 0;

    serial_slice_comparator #(.S(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready_e), .done(done_e), .EQ(eq_e), .GT(gt_e), .cycles(cy_e)
    );

    serial_slice_comparator #(.S(8), .EARLY_EXIT(1'b0)) u_dut_fw (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready_f), .done(done_f), .EQ(eq_f), .GT(gt_f), .cycles(cy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        logic       gt;
        int         cy_ee;
        int         cy_fw;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
        for (int i = 3; i >= 0; i--) begin
            if (x[2*i +: 2] != y[2*i +: 2]) return 4 - i;
        end
        return 4;
    endfunction

    // Accept one request on both instances, then watch a fixed window of cycles.
    // With poke set, start is re-asserted with different operands during RUN.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic eeq, input logic egt, input int ecy_e,
                          input int ecy_f, input bit poke);
        int lat_e, lat_f, np_e, np_f;
        lat_e = -1; lat_f = -1; np_e = 0; np_f = 0;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int k = 1; k <= 10; k++) begin
            if (done_e) begin np_e++; if (lat_e < 0) lat_e = k - 1; end
            if (done_f) begin np_f++; if (lat_f < 0) lat_f = k - 1; end
            if (poke && (k == 1 || k == 2)) begin
                start = 1'b1; a = ~va; b = ~vb;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " ee.EQ"}, int'(eq_e), int'(eeq));
        chk({tag, " ee.GT"}, int'(gt_e), int'(egt));
        chk({tag, " ee.cycles"}, int'(cy_e), ecy_e);
        chk({tag, " ee.latency"}, lat_e, ecy_e);
        chk({tag, " ee.done_pulses"}, np_e, 1);
        chk({tag, " ee.ready"}, int'(ready_e), 1);
        chk({tag, " fw.EQ"}, int'(eq_f), int'(eeq));
        chk({tag, " fw.GT"}, int'(gt_f), int'(egt));
        chk({tag, " fw.cycles"}, int'(cy_f), ecy_f);
        chk({tag, " fw.latency"}, lat_f, ecy_f);
        chk({tag, " fw.done_pulses"}, np_f, 1);
        chk({tag, " fw.ready"}, int'(ready_f), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ee.ready"}, int'(ready_e), 1);
        chk({tag, " ee.done"}, int'(done_e), 0);
        chk({tag, " ee.EQ"}, int'(eq_e), 1);
        chk({tag, " ee.GT"}, int'(gt_e), 0);
        chk({tag, " ee.cycles"}, int'(cy_e), 0);
        chk({tag, " fw.ready"}, int'(ready_f), 1);
        chk({tag, " fw.done"}, int'(done_f), 0);
        chk({tag, " fw.EQ"}, int'(eq_f), 1);
        chk({tag, " fw.GT"}, int'(gt_f), 0);
        chk({tag, " fw.cycles"}, int'(cy_f), 0);
    endtask

    initial begin
        int np;
        logic [7:0] ra, rb;

        //           a       b      EQ    GT    ee fw
        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 4, 4};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1, 4};
        vecs[2] = '{8'h34, 8'h35, 1'b0, 1'b0, 4, 4};
        vecs[3] = '{8'hF0, 8'h0F, 1'b0, 1'b1, 1, 4};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 4, 4};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 4, 4};
        vecs[6] = '{8'h12, 8'h13, 1'b0, 1'b0, 4, 4};
        vecs[7] = '{8'h4C, 8'h48, 1'b0, 1'b1, 3, 4};
        vecs[8] = '{8'h20, 8'h30, 1'b0, 1'b0, 2, 4};
        vecs[9] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1, 4};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eq,
                   vecs[i].gt, vecs[i].cy_ee, vecs[i].cy_fw, 1'b0);
        end

        // start pulsed with new operands while busy must not disturb the result
        run_op("protocol", 8'h34, 8'h35, 1'b0, 1'b0, 4, 4, 1'b1);

        // abort mid-RUN: reset values, no done pulse, then a clean request
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        np = 0;
        for (int k = 0; k < 6; k++) begin
            if (done_e || done_f) np++;
            @(negedge clk);
        end
        chk("midrun_reset no_done", np, 0);
        run_op("after_reset", 8'hF0, 8'h0F, 1'b0, 1'b1, 1, 4, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra : 8'($urandom);
            if (i % 8 == 1) rb = ra ^ (8'h1 << $urandom_range(0, 7));
            run_op($sformatf("rand%0d", i), ra, rb, ra == rb, ra > rb,
                   first_diff(ra, rb), 4, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
